// File: rtl/dna_port_resp_pkg.sv
// Shared constants for the device-DNA port responder and the DNA reader:
// ID width, default ID, counter width and FSM state encoding.
package dna_port_resp_pkg;

   localparam int DNA_WD = 57;
   localparam logic [DNA_WD-1:0] DNA_VALUE_DEF = 57'h1_2345_6789_ABCD_EF;

   // 2**CNT_WD must exceed DNA_WD so the done count is reachable before saturation.
   localparam int CNT_WD = 6;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_LOADED   = 2'd1;
   localparam logic [1:0] ST_SHIFTING = 2'd2;
   localparam logic [1:0] ST_DONE     = 2'd3;

   typedef enum logic [1:0] {
      IDLE     = ST_IDLE,
      LOADED   = ST_LOADED,
      SHIFTING = ST_SHIFTING,
      DONE     = ST_DONE
   } dna_state_e;

   localparam logic [CNT_WD-1:0] CNT_ONE = {{(CNT_WD-1){1'b0}}, 1'b1};

   function automatic logic [CNT_WD-1:0] sat_inc(input logic [CNT_WD-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

endpackage

// File: rtl/dna_port_resp_sync_edge_det.sv
// Two-flop synchronizers for the DNA port pins plus a rising-edge detector
// on the synchronized DNA clock.
module sync_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic i_dna_clk,
   input  logic i_dna_read,
   input  logic i_dna_shift,
   input  logic i_dna_din,
   output logic o_rise,
   output logic o_read_s,
   output logic o_shift_s,
   output logic o_din_s
);

   // Bit order in both stages: {din, shift, read, clk}. No reset on these flops.
   logic [3:0] meta_q;
   logic [3:0] sync_q;
   logic       clk_d_q;
   logic       clk_s;

   always_ff @(posedge clk) begin
      meta_q <= {i_dna_din, i_dna_shift, i_dna_read, i_dna_clk};
      sync_q <= meta_q;
   end

   assign clk_s = sync_q[0];

   // Preloading the synchronized level during reset means a DNA clock that is
   // already high at reset release does not register as an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_d_q <= clk_s;
      end else begin
         clk_d_q <= clk_s;
      end
   end

   assign o_rise    = clk_s & ~clk_d_q;
   assign o_read_s  = sync_q[1];
   assign o_shift_s = sync_q[2];
   assign o_din_s   = sync_q[3];

endmodule

// File: rtl/dna_port_resp.sv
// Device-DNA serial port responder: loads a programmable ID on READ and
// shifts it out MSB-first on SHIFT, tracking shift count and protocol misuse.
module dna_port_resp
   import dna_port_resp_pkg::*;
#(
   parameter int                DNA_WD    = dna_port_resp_pkg::DNA_WD,
   parameter logic [DNA_WD-1:0] DNA_VALUE = DNA_VALUE_DEF,
   parameter int                CNT_WD    = dna_port_resp_pkg::CNT_WD
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_dna_clk,
   input  logic              i_dna_read,
   input  logic              i_dna_shift,
   input  logic              i_dna_din,
   output logic              o_dna_dout,
   output logic [CNT_WD-1:0] ov_shift_cnt,
   output logic              o_shift_done,
   output logic              o_protocol_err,
   output logic [1:0]        ov_state
);

   localparam logic [CNT_WD-1:0] LAST_CNT = CNT_WD'(DNA_WD - 1);
   localparam logic [CNT_WD-1:0] CNT_MAX  = {CNT_WD{1'b1}};

   logic rise;
   logic read_s;
   logic shift_s;
   logic din_s;

   logic [DNA_WD-1:0] shreg_q;
   logic [DNA_WD-1:0] shreg_d;
   logic [CNT_WD-1:0] cnt_q;
   logic [CNT_WD-1:0] cnt_d;
   logic              done_q;
   logic              err_q;
   dna_state_e        state_q;

   sync_edge_det u_sync (
      .clk         (clk),
      .reset       (reset),
      .i_dna_clk   (i_dna_clk),
      .i_dna_read  (i_dna_read),
      .i_dna_shift (i_dna_shift),
      .i_dna_din   (i_dna_din),
      .o_rise      (rise),
      .o_read_s    (read_s),
      .o_shift_s   (shift_s),
      .o_din_s     (din_s)
   );

   always_comb begin
      shreg_d = {shreg_q[DNA_WD-2:0], din_s};
      cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + {{(CNT_WD-1){1'b0}}, 1'b1};
   end

   // Everything advances only on a synchronized DNA clock rise; READ beats SHIFT.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         state_q <= IDLE;
      end else if (rise) begin
         if (read_s) begin
            shreg_q <= DNA_VALUE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            state_q <= LOADED;
         end else if (shift_s) begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            case (state_q)
               IDLE: begin
                  err_q <= 1'b1;
               end
               LOADED, SHIFTING: begin
                  if (cnt_d == LAST_CNT) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= SHIFTING;
                  end
               end
               DONE: begin
                  err_q <= 1'b1;
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign o_dna_dout     = shreg_q[DNA_WD-1];
   assign ov_shift_cnt   = cnt_q;
   assign o_shift_done   = done_q;
   assign o_protocol_err = err_q;
   assign ov_state       = state_q;

endmodule
